max11046_conv_ctrl: RTL

Conversion and readout controller for the MAX11046 8-channel, 16-bit ADC. It sits directly upstream of the per-channel parallel-to-serial force stage. It paces conversions at a fixed sample period and waits for end-of-conversion. It then reads NUM_CH channels over the parallel bus with CS/RD strobes, presenting each 16-bit word with its channel index and a one-cycle valid strobe.

---
 rtl/max11046_conv_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/max11046_conv_ctrl.sv
// Conversion pacing and parallel readout for the MAX11046 ADC.
// One frame = CONVST pulse, wait for EOC, then NUM_CH CS/RD word reads.
module max11046_conv_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int CONVST_LOW    = 4,
  parameter int RD_LOW        = 3,
  parameter int RD_HIGH       = 2,
  parameter int NUM_CH        = 8,
  parameter int EOC_TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        eoc_n,
  input  logic [15:0] db_in,
  output logic        convst,
  output logic        cs_n,
  output logic        rd_n,
  output logic [15:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = 16;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] CONV_LAST   = TW'(CONVST_LOW - 1);
  localparam logic [TW-1:0] EOC_LAST    = TW'(EOC_TIMEOUT - 1);
  localparam logic [TW-1:0] RDL_LAST    = TW'(RD_LOW - 1);
  localparam logic [TW-1:0] RDH_LAST    = TW'(RD_HIGH - 1);
  localparam logic [2:0]    CH_LAST     = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT_EOC, READ_LO, READ_HI} state_t;

  state_t          state, state_next;
  logic            eoc_meta, eoc_s;
  logic [PW-1:0]   period_cnt;
  logic            period_last;
  logic            start_pend;
  logic [TW-1:0]   tmr;
  logic [2:0]      ch;
  logic            start, tmr_clr, capture, ch_inc, ch_clr, set_timeout;

  assign period_last = (period_cnt == PERIOD_LAST);

  // sample_valid is a one-cycle pulse with no backpressure: the consumer
  // must take sample_data/sample_ch in the cycle sample_valid is high.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    tmr_clr     = 1'b0;
    capture     = 1'b0;
    ch_inc      = 1'b0;
    ch_clr      = 1'b0;
    set_timeout = 1'b0;
    convst      = 1'b1;
    cs_n        = 1'b1;
    rd_n        = 1'b1;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable && (start_pend || period_last)) begin
          state_next = CONV;
          start      = 1'b1;
          tmr_clr    = 1'b1;
        end
      end
      CONV: begin
        convst = 1'b0;
        if (tmr == CONV_LAST) begin
          state_next = WAIT_EOC;
          tmr_clr    = 1'b1;
        end
      end
      WAIT_EOC: begin
        if (!eoc_s) begin
          state_next = READ_LO;
          tmr_clr    = 1'b1;
        end else if (tmr == EOC_LAST) begin
          state_next  = IDLE;
          set_timeout = 1'b1;
        end
      end
      READ_LO: begin
        cs_n = 1'b0;
        rd_n = 1'b0;
        if (tmr == RDL_LAST) begin
          state_next = READ_HI;
          tmr_clr    = 1'b1;
          capture    = 1'b1;
        end
      end
      READ_HI: begin
        cs_n = 1'b0;
        if (tmr == RDH_LAST) begin
          tmr_clr = 1'b1;
          if (ch == CH_LAST) begin
            state_next = IDLE;
            ch_clr     = 1'b1;
          end else begin
            state_next = READ_LO;
            ch_inc     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      eoc_meta     <= 1'b1;
      eoc_s        <= 1'b1;
      period_cnt   <= '0;
      start_pend   <= 1'b1;
      tmr          <= '0;
      ch           <= '0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_next;
      eoc_meta     <= eoc_n;
      eoc_s        <= eoc_meta;
      tmr          <= tmr_clr ? '0 : tmr + 1'b1;
      sample_valid <= capture;
      frame_done   <= capture && (ch == CH_LAST);
      if (capture) begin
        sample_data <= db_in;
        sample_ch   <= ch;
      end
      if (ch_clr) ch <= '0;
      else if (ch_inc) ch <= ch + 1'b1;
      if (start) period_cnt <= '0;
      else if (enable || state != IDLE) period_cnt <= period_last ? '0 : period_cnt + 1'b1;
      // A period boundary missed during a frame is remembered so the next
      // conversion launches as soon as the frame returns to IDLE.
      if (start) start_pend <= 1'b0;
      else if (period_last && state != IDLE) start_pend <= 1'b1;
      if (period_last && state != IDLE) overrun <= 1'b1;
      if (set_timeout) timeout_err <= 1'b1;
    end
  end
endmodule
